// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  // Command word layout: {op, rd, ra, rb}
  localparam int OP_MSB = 11;
  localparam int OP_LSB = 9;
  localparam int RD_MSB = 8;
  localparam int RD_LSB = 6;
  localparam int RA_MSB = 5;
  localparam int RA_LSB = 3;
  localparam int RB_MSB = 2;
  localparam int RB_LSB = 0;

  // Bit positions within flags = {O, C, Z, N}
  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/seq_regfile.sv
// 8-entry register file, two async read ports with write-through bypass.
// ALU_SEQ_R0_ZERO_EN: r0 hardwired to zero (writes dropped, reads 0).
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [NUM_REGS-1:0][DATA_W-1:0] rf;
  logic                            we_eff;

`ifdef ALU_SEQ_R0_ZERO_EN
  assign we_eff = we && (waddr != '0);
`else
  assign we_eff = we;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rf        <= '0;
    else if (we_eff) rf[waddr] <= wdata;
  end

  // A same-edge write is forwarded so a load and an accept can coincide;
  // gating with we_eff keeps r0 reading zero through the bypass too.
  always_comb begin
    rdata_a = rf[raddr_a];
    rdata_b = rf[raddr_b];
    if (we_eff && (raddr_a == waddr)) rdata_a = wdata;
    if (we_eff && (raddr_b == waddr)) rdata_b = wdata;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle register-to-register command sequencer around an external ALU.
// ALU_SEQ_R0_ZERO_EN (see seq_regfile) makes r0 a constant zero.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       command,
  input  logic              run,
  output logic              ready,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [OP_W-1:0]   alu_op_code,
  input  logic [DATA_W-1:0] y,
  input  logic              alu_O,
  input  logic              alu_C,
  input  logic              alu_Z,
  input  logic              alu_N,
  output logic [3:0]        flags,
  output logic              done
);

  state_t            state, state_nxt;
  logic [REG_AW-1:0] rd_q;
  logic              accept, load;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd, cmd_ra, cmd_rb;

  assign cmd_op = command[OP_MSB:OP_LSB];
  assign cmd_rd = command[RD_MSB:RD_LSB];
  assign cmd_ra = command[RA_MSB:RA_LSB];
  assign cmd_rb = command[RB_MSB:RB_LSB];

  assign ready  = (state == IDLE);
  assign accept = ready && run;
  assign load   = ready && ld_en;

  // Writeback only happens in EXEC and loads only in IDLE, so one port suffices.
  assign we    = (state == EXEC) || load;
  assign waddr = (state == EXEC) ? rd_q : ld_addr;
  assign wdata = (state == EXEC) ? y    : ld_data;

  seq_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_ra),
    .raddr_b (cmd_rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = ISSUE;
      ISSUE:   state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a      <= '0;
      data_b      <= '0;
      alu_op_code <= '0;
      rd_q        <= '0;
      flags       <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == EXEC);
      if (accept) begin
        data_a      <= rdata_a;
        data_b      <= rdata_b;
        alu_op_code <= OP_W'(cmd_op);
        rd_q        <= cmd_rd;
      end
      if (state == EXEC) begin
        flags[FLAG_O] <= alu_O;
        flags[FLAG_C] <= alu_C;
        flags[FLAG_Z] <= alu_Z;
        flags[FLAG_N] <= alu_N;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small external ALU model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] command = '0;
  logic        run = 1'b0;
  logic        ready;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] data_a, data_b;
  logic [2:0]  alu_op_code;
  logic [31:0] y;
  logic        fo, fc, fz, fn;
  logic [3:0]  flags;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .run(run), .ready(ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .data_a(data_a), .data_b(data_b), .alu_op_code(alu_op_code),
    .y(y), .alu_O(fo), .alu_C(fc), .alu_Z(fz), .alu_N(fn),
    .flags(flags), .done(done)
  );

  // External operand registers plus combinational ALU:
  // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 pass a, 6 not a, 7 pass b
  logic [31:0] opa, opb;
  logic [2:0]  opr;
  logic [32:0] sum, dif;
  always @(posedge clk) begin
    opa <= data_a;
    opb <= data_b;
    opr <= alu_op_code;
  end
  always_comb begin
    sum = {1'b0, opa} + {1'b0, opb};
    dif = {1'b0, opa} - {1'b0, opb};
    y  = '0;
    fo = 1'b0;
    fc = 1'b0;
    case (opr)
      3'd0: begin y = sum[31:0]; fc = sum[32];
                  fo = (opa[31] == opb[31]) && (sum[31] != opa[31]); end
      3'd1: begin y = dif[31:0]; fc = dif[32];
                  fo = (opa[31] != opb[31]) && (dif[31] != opa[31]); end
      3'd2: y = opa & opb;
      3'd3: y = opa | opb;
      3'd4: y = opa ^ opb;
      3'd5: y = opa;
      3'd6: y = ~opa;
      default: y = opb;
    endcase
    fz = (y == '0);
    fn = y[31];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [11:0] cmd);
    @(negedge clk);
    run = 1'b1; command = cmd;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // Edges from accept until done is seen; bounded so a stuck DUT still ends.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    if (!done) n = 99;
  endtask

  task automatic read_reg(input logic [2:0] a, input logic [31:0] exp, input string name);
    int n;
    issue({3'd5, a, a, a});
    chk(name, data_a, exp);
    wait_done(n);
    chk({name, "_lat"}, n, 2);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  op, rd, ra, rb;
    logic [31:0] va, vb, ey;
    logic [3:0]  ef;
  } vec_t;
  vec_t tbl[7];

  int          n;
  logic [31:0] r0_exp;

  initial begin
    tbl[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 32'd3,         32'd4,         32'd7,         4'b0000};
    tbl[1] = '{3'd0, 3'd4, 3'd1, 3'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0110};
    tbl[2] = '{3'd0, 3'd5, 3'd1, 3'd2, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001};
    tbl[3] = '{3'd1, 3'd7, 3'd5, 3'd6, 32'd10,        32'd3,         32'd7,         4'b0000};
    tbl[4] = '{3'd7, 3'd2, 3'd1, 3'd2, 32'd1,         32'h1234,      32'h1234,      4'b0000};
    tbl[5] = '{3'd2, 3'd3, 3'd1, 3'd2, 32'hF0F0,      32'h0F0F,      32'd0,         4'b0010};
    tbl[6] = '{3'd4, 3'd4, 3'd1, 3'd2, 32'h8000_0000, 32'd1,         32'h8000_0001, 4'b0001};

    // Reset state
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_data_b", data_b, 0);
    chk("rst_op", alu_op_code, 0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven commands
    for (int i = 0; i < 7; i++) begin
      do_load(tbl[i].ra, tbl[i].va);
      do_load(tbl[i].rb, tbl[i].vb);
      issue({tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb});
      chk($sformatf("v%0d_data_a", i), data_a, tbl[i].va);
      chk($sformatf("v%0d_data_b", i), data_b, tbl[i].vb);
      chk($sformatf("v%0d_op", i), alu_op_code, tbl[i].op);
      chk($sformatf("v%0d_ready", i), ready, 0);
      wait_done(n);
      chk($sformatf("v%0d_lat", i), n, 2);
      chk($sformatf("v%0d_flags", i), flags, tbl[i].ef);
      read_reg(tbl[i].rd, tbl[i].ey, $sformatf("v%0d_rd", i));
    end

    // Reset asserted in EXEC: command abandoned, flags cleared
    do_load(3'd1, 32'd5);
    issue({3'd0, 3'd2, 3'd1, 3'd1});
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_ready", ready, 1);
    chk("mid_flags", flags, 0);
    chk("mid_done", done, 0);
    chk("mid_data_a", data_a, 0);
    @(posedge clk); #1;
    chk("mid_done_e2", done, 0);
    @(negedge clk); rst_n = 1'b1;
    read_reg(3'd2, 32'd0, "mid_r2");
    read_reg(3'd1, 32'd0, "mid_r1");

    // Back-to-back dependency with run held
    do_load(3'd1, 32'h11);
    do_load(3'd2, 32'h22);
    @(negedge clk);
    run = 1'b1; command = {3'd0, 3'd5, 3'd1, 3'd2};
    @(posedge clk); #1;
    chk("b2b_a1", data_a, 32'h11);
    command = {3'd0, 3'd6, 3'd5, 3'd5};
    @(posedge clk); #1;
    chk("b2b_ready_e1", ready, 0);
    @(posedge clk); #1;
    chk("b2b_done_e2", done, 1);
    chk("b2b_ready_e2", ready, 1);
    @(posedge clk); #1;
    run = 1'b0;
    chk("b2b_a2", data_a, 32'h33);
    chk("b2b_b2", data_b, 32'h33);
    chk("b2b_done_e3", done, 0);
    wait_done(n);
    chk("b2b_lat2", n, 2);
    read_reg(3'd6, 32'h66, "b2b_r6");

    // Load and accept on the same edge; load during EXEC dropped
    do_reset();
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd9;
    run = 1'b1; command = {3'd0, 3'd3, 3'd1, 3'd1};
    @(posedge clk); #1;
    run = 1'b0;
    chk("col_a", data_a, 32'd9);
    chk("col_b", data_b, 32'd9);
    ld_addr = 3'd2; ld_data = 32'd77;
    wait_done(n);
    ld_en = 1'b0;
    chk("col_lat", n, 2);
    read_reg(3'd3, 32'd18, "col_r3");
    read_reg(3'd2, 32'd0, "col_r2_nold");
    read_reg(3'd1, 32'd9, "col_r1");

    // r0 behaviour (zero only when hardwired)
`ifdef ALU_SEQ_R0_ZERO_EN
    r0_exp = 32'd0;
`else
    r0_exp = 32'd7;
`endif
    do_load(3'd0, 32'd7);
    issue({3'd0, 3'd1, 3'd0, 3'd0});
    chk("r0_data_a", data_a, r0_exp);
    wait_done(n);
    read_reg(3'd1, r0_exp + r0_exp, "r0_sum");
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 32'd5;
    run = 1'b1; command = {3'd0, 3'd2, 3'd0, 3'd0};
    @(posedge clk); #1;
    ld_en = 1'b0; run = 1'b0;
`ifdef ALU_SEQ_R0_ZERO_EN
    r0_exp = 32'd0;
`else
    r0_exp = 32'd5;
`endif
    chk("r0_bypass", data_a, r0_exp);
    wait_done(n);
    chk("r0_lat", n, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
